mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the pipeline's instruction-fetch port and data-memory port. It sits between the CPU core's `i_*`/`d_*` buses and the memory's request/acknowledge interface. It serialises accesses through a small state machine and raises per-port stall flags while a port waits. It also aborts memory transactions that never acknowledge.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/arb_ack_timer.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
// Optional round-robin arbitration is enabled by MEM_ARB_RR_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IBUS,
    DBUS,
    DONE
  } arb_state_e;

  typedef enum logic {
    GNT_I,
    GNT_D
  } arb_gnt_e;

  localparam int unsigned ACK_TIMEOUT_DEF = 255;
  localparam logic [31:0] ERR_WORD_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side and memory-side bus bundle of the arbiter.
// master = arbiter side, slave = core + memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              i_read_en;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_instr_out;
  logic              i_ready;
  logic              i_stall;

  logic              d_read_en;
  logic              d_write_en;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_write_data;
  logic [DATA_W-1:0] d_data_out;
  logic              d_ready;
  logic              d_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              err;

  modport master (
    input  i_read_en, i_addr,
    output i_instr_out, i_ready, i_stall,
    input  d_read_en, d_write_en,
    input  d_addr, d_write_data,
    output d_data_out, d_ready, d_stall,
    output mem_req, mem_we,
    output mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output err
  );

  modport slave (
    output i_read_en, i_addr,
    input  i_instr_out, i_ready, i_stall,
    output d_read_en, d_write_en,
    output d_addr, d_write_data,
    input  d_data_out, d_ready, d_stall,
    input  mem_req, mem_we,
    input  mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  err
  );

endinterface

// File: rtl/arb_ack_timer.sv
// Ack watchdog: loadable counter with clear/enable.
// expired flags the edge on which the count reaches LIMIT.
module arb_ack_timer #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned W = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en & (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-ported memory.
// MEM_ARB_RR_EN selects round-robin instead of data priority.
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter logic [DATA_W-1:0] ERR_WORD =
    DATA_W'(ERR_WORD_DEF)
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.master bus
);

  arb_state_e state_q, state_d;
  arb_gnt_e   gnt_q, gnt_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] ddata_q, ddata_d;
  logic              err_q, err_d;

  logic i_req;
  logic d_req;
  logic pick_d;
  logic busy;
  logic grant;
  logic tmr_en;
  logic expired;

  assign i_req = bus.i_read_en;
  assign d_req = bus.d_read_en | bus.d_write_en;
  assign busy  = (state_q == IBUS) |
                 (state_q == DBUS);

`ifdef MEM_ARB_RR_EN
  // on a tie, the port not served last wins
  assign pick_d = d_req &
                  (~i_req | (gnt_q == GNT_I));
`else
  assign pick_d = d_req;
`endif

  assign grant  = (state_q == IDLE) &
                  (d_req | i_req);
  assign tmr_en = busy & ~bus.mem_ack;

  arb_ack_timer #(
    .LIMIT(ACK_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant),
    .load    (1'b0),
    .load_val('0),
    .en      (tmr_en),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    instr_d = instr_q;
    ddata_d = ddata_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = DBUS;
          gnt_d   = GNT_D;
          addr_d  = bus.d_addr;
          wdata_d = bus.d_write_data;
          we_d    = bus.d_write_en;
        end else if (i_req) begin
          state_d = IBUS;
          gnt_d   = GNT_I;
          addr_d  = bus.i_addr;
          we_d    = 1'b0;
        end
      end
      IBUS: begin
        if (bus.mem_ack) begin
          instr_d = bus.mem_rdata;
          state_d = DONE;
        end else if (expired) begin
          instr_d = ERR_WORD;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DBUS: begin
        if (bus.mem_ack) begin
          if (!we_q) ddata_d = bus.mem_rdata;
          state_d = DONE;
        end else if (expired) begin
          ddata_d = ERR_WORD;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= GNT_I;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      instr_q <= '0;
      ddata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      instr_q <= instr_d;
      ddata_q <= ddata_d;
      err_q   <= err_d;
    end
  end

  assign bus.i_ready = (state_q == DONE) &
                       (gnt_q == GNT_I);
  assign bus.d_ready = (state_q == DONE) &
                       (gnt_q == GNT_D);

  assign bus.i_stall = bus.i_read_en &
                       ~bus.i_ready;
  assign bus.d_stall = d_req & ~bus.d_ready;

  assign bus.i_instr_out = instr_q;
  assign bus.d_data_out  = ddata_q;
  assign bus.mem_req     = busy;
  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter, ACK_TIMEOUT = 4.
// Default build: fixed data-over-fetch priority.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(
    .ADDR_W(32),
    .DATA_W(32)
  ) bus ();

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .ACK_TIMEOUT(4),
    .ERR_WORD   (32'hDEAD_BEEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_read_en    = 1'b0;
    bus.i_addr       = '0;
    bus.d_read_en    = 1'b0;
    bus.d_write_en   = 1'b0;
    bus.d_addr       = '0;
    bus.d_write_data = '0;
    bus.mem_ack      = 1'b0;
    bus.mem_rdata    = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    bus.i_read_en = 1'b1;
    #1;
    chk("rst_i_stall", 32'(bus.i_stall), 1);
    tick();
    bus.i_read_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_req", 32'(bus.mem_req), 0);
    chk("rst_rdy", 32'({bus.i_ready,
        bus.d_ready, bus.err}), 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_data", bus.i_instr_out |
        bus.d_data_out, 0);
    chk("rst_stall", 32'({bus.i_stall,
        bus.d_stall}), 0);

    // fetch only, ack two cycles into the request
    bus.i_read_en = 1'b1;
    bus.i_addr    = 32'h100;
    #1;
    chk("f_stall0", 32'(bus.i_stall), 1);
    tick();
    chk("f_req", 32'(bus.mem_req), 1);
    chk("f_we", 32'(bus.mem_we), 0);
    chk("f_addr", bus.mem_addr, 32'h100);
    chk("f_stall1", 32'(bus.i_stall), 1);
    tick();
    chk("f_req2", 32'(bus.mem_req), 1);
    chk("f_rdy0", 32'(bus.i_ready), 0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h2008_0005;
    tick();
    bus.mem_ack = 1'b0;
    chk("f_rdy", 32'(bus.i_ready), 1);
    chk("f_data", bus.i_instr_out,
        32'h2008_0005);
    chk("f_req_lo", 32'(bus.mem_req), 0);
    chk("f_stall2", 32'(bus.i_stall), 0);
    bus.i_read_en = 1'b0;
    tick();
    chk("f_rdy_once", 32'(bus.i_ready), 0);

    // stray ack in IDLE is ignored
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_0999;
    tick();
    bus.mem_ack = 1'b0;
    chk("ign_data", bus.i_instr_out,
        32'h2008_0005);
    chk("ign_req", 32'({bus.mem_req,
        bus.i_ready, bus.d_ready}), 0);

    // simultaneous store and fetch
    bus.d_write_en   = 1'b1;
    bus.d_addr       = 32'h40;
    bus.d_write_data = 32'h1234;
    bus.i_read_en    = 1'b1;
    bus.i_addr       = 32'h104;
    tick();
    chk("s_req", 32'(bus.mem_req), 1);
    chk("s_we", 32'(bus.mem_we), 1);
    chk("s_addr", bus.mem_addr, 32'h40);
    chk("s_wdata", bus.mem_wdata, 32'h1234);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hAAAA_5555;
    tick();
    bus.mem_ack = 1'b0;
    chk("s_drdy", 32'(bus.d_ready), 1);
    chk("s_irdy", 32'(bus.i_ready), 0);
    chk("s_dkeep", bus.d_data_out, 0);
    chk("s_istall", 32'(bus.i_stall), 1);
    chk("s_dstall", 32'(bus.d_stall), 0);
    bus.d_write_en = 1'b0;
    tick();
    chk("s_idle", 32'(bus.mem_req), 0);
    tick();
    chk("s_f_req", 32'(bus.mem_req), 1);
    chk("s_f_we", 32'(bus.mem_we), 0);
    chk("s_f_addr", bus.mem_addr, 32'h104);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_0013;
    tick();
    bus.mem_ack = 1'b0;
    chk("s_f_rdy", 32'(bus.i_ready), 1);
    chk("s_f_data", bus.i_instr_out, 32'h13);
    bus.i_read_en = 1'b0;
    tick();

    // zero-wait fetch stream, 3 cycles each
    bus.i_read_en = 1'b1;
    bus.i_addr    = 32'h200;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("z_req", 32'(bus.mem_req), 1);
      chk("z_addr", bus.mem_addr,
          32'h200 + 32'(4 * k));
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h1000 + 32'(k);
      tick();
      bus.mem_ack = 1'b0;
      chk("z_rdy", 32'(bus.i_ready), 1);
      chk("z_data", bus.i_instr_out,
          32'h1000 + 32'(k));
      if (k < 2) bus.i_addr = bus.i_addr + 4;
      else bus.i_read_en = 1'b0;
      tick();
      chk("z_gap", 32'({bus.mem_req,
          bus.i_ready}), 0);
    end

    // timeout on a load that never acks
    bus.d_read_en = 1'b1;
    bus.d_addr    = 32'h80;
    tick();
    for (int c = 0; c < 4; c++) begin
      chk("t_req", 32'(bus.mem_req), 1);
      chk("t_err0", 32'(bus.err), 0);
      tick();
    end
    chk("t_req_lo", 32'(bus.mem_req), 0);
    chk("t_err", 32'(bus.err), 1);
    chk("t_drdy", 32'(bus.d_ready), 1);
    chk("t_data", bus.d_data_out,
        32'hDEAD_BEEF);
    bus.d_read_en = 1'b0;
    tick();
    chk("t_err_pulse", 32'({bus.err,
        bus.d_ready}), 0);

    // ack on the timeout edge wins
    bus.d_read_en = 1'b1;
    bus.d_addr    = 32'h84;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("r_req", 32'(bus.mem_req), 1);
      tick();
    end
    chk("r_req4", 32'(bus.mem_req), 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h55AA_1234;
    tick();
    bus.mem_ack = 1'b0;
    chk("r_err", 32'(bus.err), 0);
    chk("r_drdy", 32'(bus.d_ready), 1);
    chk("r_data", bus.d_data_out,
        32'h55AA_1234);
    bus.d_read_en = 1'b0;
    tick();

    // reset during DBUS
    bus.d_read_en = 1'b1;
    bus.d_addr    = 32'h88;
    tick();
    chk("x_req", 32'(bus.mem_req), 1);
    rst = 1'b1;
    bus.d_read_en = 1'b0;
    bus.mem_ack   = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_ack = 1'b0;
    chk("x_req_lo", 32'({bus.mem_req,
        bus.mem_we}), 0);
    chk("x_flags", 32'({bus.i_ready,
        bus.d_ready, bus.err}), 0);
    chk("x_addr", bus.mem_addr, 0);
    chk("x_data", bus.d_data_out |
        bus.i_instr_out, 0);
    bus.i_read_en = 1'b1;
    bus.i_addr    = 32'h300;
    tick();
    chk("x_f_addr", bus.mem_addr, 32'h300);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_0001;
    tick();
    bus.mem_ack = 1'b0;
    chk("x_f_rdy", 32'({bus.i_ready,
        bus.d_ready}), 32'b10);
    chk("x_f_data", bus.i_instr_out,
        32'hCAFE_0001);
    bus.i_read_en = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
